// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared definitions for the local-port injection arbiter: flit width and packet FSM states.
package noc_local_inject_arbiter_pkg;

  localparam int unsigned TAM_FLIT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD,
    S_DONE
  } inject_state_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_local_inject_arbiter_if.sv
// Requester-side and router-local-port signals of the injection arbiter.
interface noc_local_inject_arbiter_if #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TAM_FLIT = noc_local_inject_arbiter_pkg::TAM_FLIT,
  parameter int unsigned CNT_W    = 16
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*TAM_FLIT-1:0] req_target;
  logic [N_REQ*TAM_FLIT-1:0] req_size;
  logic [N_REQ*TAM_FLIT-1:0] pl_data;
  logic [N_REQ-1:0]          pl_valid;
  logic [N_REQ-1:0]          pl_ready;
  logic [N_REQ-1:0]          grant;
  logic [N_REQ-1:0]          done;
  logic                      tx;
  logic [TAM_FLIT-1:0]       data_out;
  logic                      credit_i;
  logic                      busy;
  logic [CNT_W-1:0]          pkt_count;

  modport master (
    output req, req_target, req_size, pl_data, pl_valid, credit_i,
    input  pl_ready, grant, done, tx, data_out, busy, pkt_count
  );

  modport slave (
    input  req, req_target, req_size, pl_data, pl_valid, credit_i,
    output pl_ready, grant, done, tx, data_out, busy, pkt_count
  );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module noc_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Shares one router local input among N_REQ requesters; serialises header, size and payload flits.
module noc_local_inject_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TAM_FLIT = noc_local_inject_arbiter_pkg::TAM_FLIT,
  parameter int unsigned CNT_W    = 16
) (
  input logic                     clock,
  input logic                     reset,
  noc_local_inject_arbiter_if.slave bus
);
  import noc_local_inject_arbiter_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_REQ);

  inject_state_t       state_q, state_d;
  logic [N_REQ-1:0]    arb_grant, grant_q;
  logic [IDX_W-1:0]    arb_idx, owner_q, rr_ptr_q;
  logic                arb_any;
  logic [TAM_FLIT-1:0] target_q, size_q, remaining_q;
  logic [TAM_FLIT-1:0] sel_target, sel_size, owner_data;
  logic                owner_valid, xfer;
  logic [CNT_W-1:0]    pkt_count_q;
  logic                tx_d;
  logic [TAM_FLIT-1:0] data_d;
  logic [N_REQ-1:0]    grant_d, done_d, ready_d;

  noc_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Muxes keyed by one-hot vectors keep every slice index constant.
  always_comb begin
    sel_target  = '0;
    sel_size    = '0;
    owner_data  = '0;
    owner_valid = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_target = bus.req_target[i*TAM_FLIT +: TAM_FLIT];
        sel_size   = bus.req_size[i*TAM_FLIT +: TAM_FLIT];
      end
      if (grant_q[i]) begin
        owner_data  = bus.pl_data[i*TAM_FLIT +: TAM_FLIT];
        owner_valid = bus.pl_valid[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = 1'b0;
    data_d  = '0;
    grant_d = '0;
    done_d  = '0;
    ready_d = '0;
    xfer    = 1'b0;
    case (state_q)
      S_IDLE: if (arb_any) state_d = S_HEADER;
      S_HEADER: begin
        grant_d = grant_q;
        tx_d    = 1'b1;
        data_d  = target_q;
        if (bus.credit_i) state_d = S_SIZE;
      end
      S_SIZE: begin
        grant_d = grant_q;
        tx_d    = 1'b1;
        data_d  = size_q;
        if (bus.credit_i) state_d = (size_q != '0) ? S_PAYLOAD : S_DONE;
      end
      S_PAYLOAD: begin
        grant_d = grant_q;
        tx_d    = owner_valid;
        data_d  = owner_data;
        xfer    = owner_valid & bus.credit_i;
        ready_d = grant_q & {N_REQ{xfer}};
        if (xfer && remaining_q == TAM_FLIT'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = grant_q;
        done_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      target_q    <= '0;
      size_q      <= '0;
      remaining_q <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (arb_any) begin
          grant_q  <= arb_grant;
          owner_q  <= arb_idx;
          target_q <= sel_target;
          size_q   <= sel_size;
        end
        S_SIZE:    remaining_q <= size_q;
        S_PAYLOAD: if (xfer) remaining_q <= remaining_q - TAM_FLIT'(1);
        S_DONE: begin
          pkt_count_q <= pkt_count_q + CNT_W'(1);
          rr_ptr_q    <= IDX_W'(wrap_inc(32'(owner_q), N_REQ));
        end
        default: ;
      endcase
    end
  end

  assign bus.tx        = tx_d;
  assign bus.data_out  = data_d;
  assign bus.grant     = grant_d;
  assign bus.done      = done_d;
  assign bus.pl_ready  = ready_d;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.pkt_count = pkt_count_q;
endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Directed and randomized bench for noc_local_inject_arbiter against a packet-level reference model.
module tb_noc_local_inject_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  noc_local_inject_arbiter_if #(.N_REQ(N), .TAM_FLIT(W), .CNT_W(CW)) bus ();

  noc_local_inject_arbiter #(.N_REQ(N), .TAM_FLIT(W), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int unsigned owner;
    logic [15:0] target;
    logic [15:0] size;
    int unsigned base;
  } pkt_t;

  pkt_t        pkts[$];
  logic [15:0] pl_mem[$];
  int unsigned rq[N][$];
  int unsigned pidx[N];

  int unsigned m_ptr, m_cur, m_id, m_fidx, m_count;
  bit          m_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned valid_pct = 100;
  int unsigned credit_pct = 100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit roll(input int unsigned pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic int unsigned pending();
    int unsigned s = 0;
    for (int unsigned i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  // Reference: owner is the first requester with queued packets at or after the pointer.
  function automatic bit pick();
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned c = (m_ptr + k) % N;
      if (rq[c].size() != 0) begin
        m_cur  = c;
        m_id   = rq[c][0];
        m_fidx = 0;
        m_busy = 1'b1;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_flit(input int unsigned id, input int unsigned f);
    if (f == 0) return {16'h0, pkts[id].target};
    if (f == 1) return {16'h0, pkts[id].size};
    if (f - 2 < 32'(pkts[id].size)) return {16'h0, pl_mem[pkts[id].base + f - 2]};
    return 32'hDEAD_0000;
  endfunction

  task automatic add_pkt(input int unsigned owner, input logic [15:0] target,
                         input logic [15:0] size, input logic [15:0] first, input bit rnd);
    pkt_t p;
    p.owner  = owner;
    p.target = target;
    p.size   = size;
    p.base   = pl_mem.size();
    for (int unsigned k = 0; k < 32'(size); k++)
      pl_mem.push_back(rnd ? 16'($urandom) : first + 16'(k));
    rq[owner].push_back(pkts.size());
    pkts.push_back(p);
  endtask

  // Requesters present their head packet while waiting and scramble fields once granted.
  task automatic drive();
    for (int unsigned i = 0; i < N; i++) begin
      bit have, own;
      have = rq[i].size() != 0;
      own  = bus.busy && bus.grant[i];
      bus.req[i] = have;
      if (have && !own) begin
        bus.req_target[i*W +: W] = pkts[rq[i][0]].target;
        bus.req_size[i*W +: W]   = pkts[rq[i][0]].size;
      end else begin
        bus.req_target[i*W +: W] = 16'($urandom);
        bus.req_size[i*W +: W]   = 16'($urandom);
      end
      if (have && own && pidx[i] < 32'(pkts[rq[i][0]].size)) begin
        bus.pl_valid[i]       = roll(valid_pct);
        bus.pl_data[i*W +: W] = pl_mem[pkts[rq[i][0]].base + pidx[i]];
      end else begin
        bus.pl_valid[i]       = !own && roll(50);
        bus.pl_data[i*W +: W] = 16'($urandom);
      end
    end
    bus.credit_i = roll(credit_pct);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drive();
    #1;
  endtask

  task automatic clear_model();
    for (int unsigned i = 0; i < N; i++) begin
      rq[i].delete();
      pidx[i] = 0;
    end
    m_busy = 1'b0; m_ptr = 0; m_count = 0; m_fidx = 0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_model();
    drive();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.done == '0 && cycles < budget);
    chk("done_within_budget", 32'(bus.done != '0), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_tx"}, 32'(bus.tx), 32'd0);
    chk({tag, "_data"}, 32'(bus.data_out), 32'd0);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pl_ready"}, 32'(bus.pl_ready), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_pkt_count"}, 32'(bus.pkt_count), 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("pl_ready_non_owner", 32'(bus.pl_ready & ~bus.grant), 32'd0);
      if (bus.tx && bus.credit_i) begin
        if (m_busy || pick()) begin
          chk("flit_data", 32'(bus.data_out), exp_flit(m_id, m_fidx));
          chk("flit_grant", 32'(bus.grant), 32'(1) << m_cur);
          m_fidx++;
        end else begin
          chk("spurious_flit", 32'({bus.tx, bus.credit_i}), 32'd0);
        end
      end
      for (int unsigned i = 0; i < N; i++) if (bus.pl_ready[i]) pidx[i]++;
      if (bus.done != '0) begin
        if (m_busy || pick()) begin
          chk("done_owner", 32'(bus.done), 32'(1) << m_cur);
          chk("done_flit_count", m_fidx, 32'(pkts[m_id].size) + 2);
          chk("pkt_count_at_done", 32'(bus.pkt_count), m_count % 65536);
          void'(rq[m_cur].pop_front());
          pidx[m_cur] = 0;
          m_ptr  = (m_cur + 1) % N;
          m_busy = 1'b0;
          m_count++;
        end else begin
          chk("spurious_done", 32'(bus.done), 32'd0);
        end
      end
    end
  end

  initial begin
    int unsigned cyc;
    logic [15:0] seq [5];
    logic [3:0]  fair [5];

    clear_model();
    drive();
    reset_dut();

    // Idle after reset
    repeat (10) begin
      tick();
      chk_quiet("idle");
    end

    // Single packet
    seq = '{16'h0011, 16'h0003, 16'h00A1, 16'h00A2, 16'h00A3};
    add_pkt(0, 16'h0011, 16'd3, 16'h00A1, 1'b0);
    drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("single_tx", 32'(bus.tx), 32'd1);
      chk("single_data", 32'(bus.data_out), 32'(seq[k]));
    end
    tick();
    chk("single_done", 32'(bus.done), 32'b0001);
    chk("single_tx_off", 32'(bus.tx), 32'd0);
    tick();
    chk("single_done_clear", 32'(bus.done), 32'd0);
    chk("single_pkt_count", 32'(bus.pkt_count), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd0);

    // Backpressure in SIZE
    add_pkt(0, 16'h0011, 16'd3, 16'h00A1, 1'b0);
    drive();
    tick();
    chk("bp_header", 32'(bus.data_out), 32'h0011);
    credit_pct = 0;
    repeat (4) begin
      tick();
      chk("bp_hold_tx", 32'(bus.tx), 32'd1);
      chk("bp_hold_data", 32'(bus.data_out), 32'h0003);
      chk("bp_pl_ready", 32'(bus.pl_ready), 32'd0);
    end
    credit_pct = 100;
    tick();
    chk("bp_size_xfer", 32'(bus.data_out), 32'h0003);
    tick();
    chk("bp_first_payload", 32'(bus.data_out), 32'h00A1);
    chk("bp_pl_ready_on", 32'(bus.pl_ready), 32'b0001);
    wait_done(20, cyc);
    tick();
    chk("bp_pkt_count", 32'(bus.pkt_count), 32'd2);

    // Fairness: all four requesting, requester 0 has a second packet
    reset_dut();
    for (int unsigned i = 0; i < N; i++) add_pkt(i, 16'(16'h0100 + i), 16'd1, 16'(16'h00F0 + i), 1'b0);
    add_pkt(0, 16'h0105, 16'd1, 16'h00F5, 1'b0);
    drive();
    fair = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      wait_done(20, cyc);
      chk("fair_order", 32'(bus.done), 32'(fair[k]));
      chk("fair_period", cyc, 32'd4);
      tick();
      chk("fair_done_pulse", 32'(bus.done), 32'd0);
    end
    chk("fair_pkt_count", 32'(bus.pkt_count), 32'd5);

    // Zero-size packet
    add_pkt(1, 16'h0102, 16'd0, 16'h0000, 1'b0);
    drive();
    tick();
    chk("zero_header", 32'(bus.data_out), 32'h0102);
    chk("zero_grant", 32'(bus.grant), 32'b0010);
    tick();
    chk("zero_size_tx", 32'(bus.tx), 32'd1);
    chk("zero_size_data", 32'(bus.data_out), 32'h0000);
    tick();
    chk("zero_done", 32'(bus.done), 32'b0010);
    tick();

    // Payload gap
    add_pkt(2, 16'h0203, 16'd2, 16'h00B1, 1'b0);
    drive();
    tick();
    tick();
    tick();
    chk("gap_first", 32'(bus.data_out), 32'h00B1);
    chk("gap_first_tx", 32'(bus.tx), 32'd1);
    valid_pct = 0;
    repeat (3) begin
      tick();
      chk("gap_tx", 32'(bus.tx), 32'd0);
      chk("gap_pl_ready", 32'(bus.pl_ready), 32'd0);
      chk("gap_grant", 32'(bus.grant), 32'b0100);
    end
    valid_pct = 100;
    tick();
    chk("gap_second", 32'(bus.data_out), 32'h00B2);
    chk("gap_second_tx", 32'(bus.tx), 32'd1);
    tick();
    chk("gap_done", 32'(bus.done), 32'b0100);
    tick();

    // Reset during PAYLOAD with two flits left
    add_pkt(0, 16'h0300, 16'd3, 16'h00C1, 1'b0);
    drive();
    tick();
    tick();
    tick();
    tick();
    chk("mid_payload", 32'(bus.data_out), 32'h00C2);
    reset = 1'b1;
    clear_model();
    drive();
    tick();
    chk_quiet("mid_reset");
    reset = 1'b0;
    add_pkt(2, 16'h0402, 16'd1, 16'h0000, 1'b1);
    add_pkt(3, 16'h0403, 16'd1, 16'h0000, 1'b1);
    drive();
    wait_done(20, cyc);
    chk("post_reset_first", 32'(bus.done), 32'b0100);
    wait_done(20, cyc);
    chk("post_reset_second", 32'(bus.done), 32'b1000);
    tick();

    // Randomized traffic
    valid_pct  = 75;
    credit_pct = 60;
    for (int r = 0; r < 25; r++) begin
      int unsigned guard;
      for (int unsigned i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, 3))
            add_pkt(i, 16'($urandom), 16'($urandom_range(0, 6)), 16'h0000, 1'b1);
      drive();
      guard = 0;
      while ((pending() != 0 || bus.busy) && guard < 3000) begin
        tick();
        guard++;
      end
      chk("round_drained", pending(), 32'd0);
      chk("round_idle", 32'(bus.busy), 32'd0);
      tick();
    end
    chk("final_pkt_count", 32'(bus.pkt_count), m_count % 65536);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
